// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction RAM port, instruction handshake to the controller,
// branch redirect and halt status.
interface fetch_unit_if;
  logic [10:0] ram_addr1;
  logic [31:0] ram_rd_data1;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [10:0] pc_out;
  logic [3:0]  cond;
  logic [6:0]  opcode;
  logic        P;
  logic        U;
  logic        W;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        halted;

  modport master (
    output ram_addr1,
    input  ram_rd_data1,
    input  instr_ready,
    output instr_valid, instr, pc_out, cond, opcode, P, U, W,
    input  redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  ram_addr1,
    output ram_rd_data1,
    output instr_ready,
    input  instr_valid, instr, pc_out, cond, opcode, P, U, W,
    output redirect, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, waits out RAM latency, holds the fetched
// word with decoded fields until the controller accepts it; handles redirect and HLT.
module fetch_unit #(
  parameter logic [10:0] RESET_PC = 11'd0,
  parameter int unsigned RAM_LAT  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, HALTED} state_t;

  state_t      r_state, w_state;
  logic [10:0] r_pc, w_pc;
  logic [10:0] r_pc_out, w_pc_out;
  logic [31:0] r_instr, w_instr;
  logic        r_valid, w_valid;
  logic        r_halted, w_halted;
  logic [2:0]  r_cnt, w_cnt;
  logic        w_accept;
  logic        w_hlt;
  logic        w_capture;

  assign w_accept = (r_state == HOLD) && r_valid && bus.instr_ready;
  assign w_hlt    = w_accept && (r_instr[27:21] == 7'b0000001) && (r_instr[31:28] != 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_pc     <= w_pc;
      r_pc_out <= w_pc_out;
      r_instr  <= w_instr;
      r_valid  <= w_valid;
      r_halted <= w_halted;
      r_cnt    <= w_cnt;
    end
  end

  // Priority: HLT acceptance, then redirect, then normal sequencing.
  // Redirect bypasses the capture path so in-flight RAM data is never latched.
  always_comb begin
    w_state   = r_state;
    w_pc      = r_pc;
    w_pc_out  = r_pc_out;
    w_instr   = r_instr;
    w_valid   = r_valid;
    w_halted  = r_halted;
    w_cnt     = r_cnt;
    w_capture = 1'b0;

    if (w_hlt) begin
      w_halted = 1'b1;
      w_valid  = 1'b0;
      w_state  = HALTED;
    end else if (bus.redirect && (r_state != HALTED)) begin
      w_pc    = bus.redirect_pc;
      w_valid = 1'b0;
      w_cnt   = '0;
      w_state = ISSUE;
    end else begin
      case (r_state)
        IDLE: w_state = ISSUE;
        ISSUE: begin
          w_cnt = 3'(RAM_LAT - 1);
          if (RAM_LAT == 1) begin
            w_capture = 1'b1;
          end else begin
            w_state = WAIT;
          end
        end
        WAIT: begin
          w_cnt = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_cnt     = '0;
            w_capture = 1'b1;
          end
        end
        HOLD: begin
          if (w_accept) begin
            w_pc    = r_pc + 11'd1;
            w_valid = 1'b0;
            w_state = ISSUE;
          end
        end
        HALTED:  w_state = HALTED;
        default: w_state = IDLE;
      endcase

      if (w_capture) begin
        w_instr  = bus.ram_rd_data1;
        w_pc_out = r_pc;
        w_valid  = 1'b1;
        w_state  = HOLD;
      end
    end
  end

  assign bus.ram_addr1   = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.pc_out      = r_pc_out;
  assign bus.halted      = r_halted;
  assign bus.cond        = r_instr[31:28];
  assign bus.opcode      = r_instr[27:21];
  assign bus.P           = r_instr[24];
  assign bus.U           = r_instr[23];
  assign bus.W           = r_instr[21];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a RAM model with 2-cycle read latency,
// directed fetch/redirect/HLT/wrap/reset sequences, and an acceptance monitor.
module tb_fetch_unit;

  typedef struct {
    logic [10:0] pc;
    logic [31:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(11'd0), .RAM_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] mem [0:2047];
  logic [31:0] ram_q;
  always @(posedge clk) ram_q <= mem[bus.ram_addr1];
  assign bus.ram_rd_data1 = ram_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [10:0] pc);
    exp_t e;
    e.pc = pc;
    e.w  = mem[pc];
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int c);
    c = -1;
    for (int i = 0; i < 20 && c < 0; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1) c = cyc;
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: instr_valid got 0 for 20 cycles expected 1", name);
    end
  endtask

  task automatic wait_accept(input string name, output int c);
    c = -1;
    for (int i = 0; i < 20 && c < 0; i++) begin
      @(negedge clk);
      if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) c = cyc;
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: accept got none in 20 cycles expected one", name);
    end
  endtask

  task automatic accept_one();
    step();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic redirect_to(input logic [10:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL acc_unexpected: got accept of pc_out %0d expected none", bus.pc_out);
      end else begin
        mon_e = sb.pop_front();
        chk("acc_pc", 32'(bus.pc_out), 32'(mon_e.pc));
        chk("acc_instr", bus.instr, mon_e.w);
        chk("acc_fields", 32'({bus.cond, bus.opcode, bus.P, bus.U, bus.W}),
            32'({mon_e.w[31:28], mon_e.w[27:21], mon_e.w[24], mon_e.w[23], mon_e.w[21]}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 expected earlier");
    $fatal(1);
  end

  initial begin
    int base;
    int c;
    int prev;

    for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0]  = 32'hE000_0000;
    mem[2]  = 32'hE1B0_0000;
    mem[5]  = 32'hDEAD_0005;
    mem[50] = 32'hF020_0000;
    mem[60] = 32'hE020_0000;

    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr1), 32'd0);
    chk("rst_pc_out", 32'(bus.pc_out), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);

    // First fetch after reset release
    rst_n = 1'b1;
    base  = cyc;
    wait_valid("first_valid", c);
    chk("first_valid_cycle", 32'(c - base), 32'd3);
    chk("first_instr", bus.instr, 32'hE000_0000);
    chk("first_cond", 32'(bus.cond), 32'hE);
    chk("first_pc_out", 32'(bus.pc_out), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold_instr", bus.instr, 32'hE000_0000);
      chk("hold_pc_out", 32'(bus.pc_out), 32'd0);
    end

    // Streaming with ready high over addresses 0..4
    for (int k = 0; k < 5; k++) push(11'(k));
    step();
    bus.instr_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept("stream_accept", c);
      if (k > 0) chk("stream_spacing", 32'(c - prev), 32'd3);
      prev = c;
      step();
      chk("stream_addr", 32'(bus.ram_addr1), 32'(k + 1));
      if (k == 4) bus.instr_ready = 1'b0;
    end

    // Redirect pulse during WAIT of address 5
    step();
    base = cyc;
    redirect_to(11'd100);
    push(11'd100);
    wait_valid("redir_valid", c);
    chk("redir_latency", 32'(c - base), 32'd3);
    chk("redir_pc_out", 32'(bus.pc_out), 32'd100);
    accept_one();

    // Accept of address 7 with simultaneous redirect to 40
    redirect_to(11'd7);
    push(11'd7);
    wait_valid("hold7_valid", c);
    step();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 11'd40;
    step();
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    chk("acc_redir_addr", 32'(bus.ram_addr1), 32'd40);
    push(11'd40);
    wait_valid("acc_redir_valid", c);
    chk("acc_redir_pc_out", 32'(bus.pc_out), 32'd40);
    accept_one();

    // PC wrap from 2047 to 0
    redirect_to(11'd2047);
    push(11'd2047);
    wait_valid("wrap_top_valid", c);
    accept_one();
    push(11'd0);
    wait_valid("wrap_valid", c);
    chk("wrap_pc_out", 32'(bus.pc_out), 32'd0);
    accept_one();

    // HLT opcode with cond F is an ordinary instruction
    redirect_to(11'd50);
    push(11'd50);
    wait_valid("hltf_valid", c);
    accept_one();
    chk("hltf_halted", 32'(bus.halted), 32'd0);
    push(11'd51);
    wait_valid("hltf_next_valid", c);
    chk("hltf_next_pc_out", 32'(bus.pc_out), 32'd51);
    chk("hltf_next_halted", 32'(bus.halted), 32'd0);
    accept_one();

    // Real HLT, accepted together with a redirect: HLT wins
    redirect_to(11'd60);
    push(11'd60);
    wait_valid("hlt_valid", c);
    step();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 11'd100;
    step();
    bus.redirect = 1'b0;
    chk("hlt_halted", 32'(bus.halted), 32'd1);
    chk("hlt_valid_low", 32'(bus.instr_valid), 32'd0);
    chk("hlt_addr", 32'(bus.ram_addr1), 32'd60);
    redirect_to(11'd200);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt_valid", 32'(bus.instr_valid), 32'd0);
      chk("halt_halted", 32'(bus.halted), 32'd1);
      chk("halt_addr", 32'(bus.ram_addr1), 32'd60);
    end
    bus.instr_ready = 1'b0;

    // Reset out of HALTED
    rst_n = 1'b0;
    #1;
    chk("rst_halt_halted", 32'(bus.halted), 32'd0);
    chk("rst_halt_addr", 32'(bus.ram_addr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-HOLD while holding address 9
    step();
    redirect_to(11'd9);
    wait_valid("hold9_valid", c);
    chk("hold9_pc_out", 32'(bus.pc_out), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_hold_pc_out", 32'(bus.pc_out), 32'd0);
    chk("rst_hold_instr", bus.instr, 32'd0);
    chk("rst_hold_addr", 32'(bus.ram_addr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-WAIT of address 9
    step();
    redirect_to(11'd9);
    step();
    chk("wait9_addr", 32'(bus.ram_addr1), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_wait_addr", 32'(bus.ram_addr1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    wait_valid("restart_valid", c);
    chk("restart_cycle", 32'(c - base), 32'd3);
    chk("restart_pc_out", 32'(bus.pc_out), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
